seg_scan_blank: RTL and testbench

SEG_SCAN_BLANK -- requirements
Module: seg_scan_blank

---
 rtl/seg_scan_blank_if.sv | 26 ++
 rtl/seg_scan_blank.sv | 81 ++++++++
 tb/tb_seg_scan_blank.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_blank_if.sv
// Display-side bundle for seg_scan_blank: value/hold in, scan index/nibble/enables/wrap out.
// The master drives the value to show; the slave is the scanner.
interface seg_scan_blank_if #(
  parameter int unsigned DIGITS = 8
);
  localparam int unsigned AN_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // With one digit there are no enable bits; a single bit is kept and held low.
  localparam int unsigned EN_HI = (DIGITS > 1) ? DIGITS - 1 : 1;

  logic [4*DIGITS-1:0] d;
  logic                hold;
  logic [AN_W-1:0]     an;
  logic [3:0]          data;
  logic [EN_HI:1]      en;
  logic                wrap;

  modport master (
    output d, hold,
    input  an, data, en, wrap
  );

  modport slave (
    input  d, hold,
    output an, data, en, wrap
  );
endinterface

// File: rtl/seg_scan_blank.sv
// Multiplexed hex display scanner with per-frame snapshot of the value.
// Define SEG_SCAN_LZB_EN to blank leading zero digits (shortens the scan to the top nonzero digit).
module seg_scan_blank #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_blank_if.slave   bus
);
  localparam int unsigned AN_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned EN_HI = (DIGITS > 1) ? DIGITS - 1 : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AN_W-1:0]     an_q, an_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                wrap_q, wrap_d;
  logic                tick;
  logic [AN_W-1:0]     top;
  logic [EN_HI:1]      en_vec;

`ifdef SEG_SCAN_LZB_EN
  // A digit is enabled when it or any more significant snapshot digit is nonzero.
  always_comb begin : lzb
    logic seen;
    seen   = 1'b0;
    en_vec = '0;
    top    = '0;
    for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
      seen      = seen | (|shadow_q[4*k +: 4]);
      en_vec[k] = seen;
    end
    for (int unsigned k = 1; k < DIGITS; k++) begin
      if (en_vec[k]) top = AN_W'(k);
    end
  end
`else
  always_comb begin : no_lzb
    en_vec = (DIGITS > 1) ? '1 : '0;
    top    = AN_W'(DIGITS - 1);
  end
`endif

  always_comb begin : next_state
    tick     = (cnt_q == CNT_W'(SCAN_DIV - 1));
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    an_d     = an_q;
    shadow_d = shadow_q;
    wrap_d   = 1'b0;
    if (tick) begin
      if (an_q < top) begin
        an_d = an_q + AN_W'(1);
      end else begin
        // End of frame: restart at digit 0 and take the next snapshot unless frozen.
        an_d   = '0;
        wrap_d = 1'b1;
        if (!bus.hold) shadow_d = bus.d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      an_q     <= '0;
      shadow_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      an_q     <= an_d;
      shadow_q <= shadow_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.an   = an_q;
  assign bus.data = shadow_q[{an_q, 2'b00} +: 4];
  assign bus.en   = en_vec;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_seg_scan_blank.sv
// Bench for seg_scan_blank: directed scenarios plus random traffic against a frame-queue model.
module tb_seg_scan_blank;
  localparam int unsigned SD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seg_scan_blank_if #(.DIGITS(4)) if4 ();
  seg_scan_blank_if #(.DIGITS(1)) if1 ();

  seg_scan_blank #(.DIGITS(4), .SCAN_DIV(SD)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  seg_scan_blank #(.DIGITS(1), .SCAN_DIV(1))  dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Reference model: a frame is the list of digit indices still to visit.
  int          m_cyc;
  logic [15:0] m_sh;
  int          m_an;
  int          frame[$];
  logic        m_wrap;
  logic [3:0]  m1_sh;
  logic        m1_wrap;

  function automatic int m_top(input logic [15:0] s);
    int t;
    t = 0;
`ifdef SEG_SCAN_LZB_EN
    for (int k = 1; k < 4; k++) if ((s >> (4*k)) != 16'h0) t = k;
`else
    t = 3;
`endif
    return t;
  endfunction

  function automatic logic [2:0] m_en(input logic [15:0] s);
    logic [2:0] e;
    e = 3'b000;
    for (int k = 1; k < 4; k++) begin
`ifdef SEG_SCAN_LZB_EN
      e[k-1] = ((s >> (4*k)) != 16'h0);
`else
      e[k-1] = 1'b1;
`endif
    end
    return e;
  endfunction

  task automatic new_frame();
    frame = {};
    for (int k = 1; k <= m_top(m_sh); k++) frame.push_back(k);
  endtask

  task automatic model_reset();
    m_cyc   = 0;
    m_sh    = 16'h0;
    m_an    = 0;
    m_wrap  = 1'b0;
    m1_sh   = 4'h0;
    m1_wrap = 1'b0;
    new_frame();
  endtask

  task automatic model_edge();
    m_wrap = 1'b0;
    if (m_cyc == int'(SD) - 1) begin
      m_cyc = 0;
      if (frame.size() == 0) begin
        m_an   = 0;
        m_wrap = 1'b1;
        if (!if4.hold) m_sh = if4.d;
        new_frame();
      end else begin
        m_an = frame.pop_front();
      end
    end else begin
      m_cyc++;
    end
    m1_wrap = 1'b1;
    if (!if1.hold) m1_sh = if1.d;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("an",    64'(if4.an),   64'(m_an));
    chk("data",  64'(if4.data), 64'((m_sh >> (4*m_an)) & 16'hF));
    chk("en",    64'(if4.en),   64'(m_en(m_sh)));
    chk("wrap",  64'(if4.wrap), 64'(m_wrap));
    chk("an1",   64'(if1.an),   64'h0);
    chk("data1", 64'(if1.data), 64'(m1_sh));
    chk("en1",   64'(if1.en),   64'h0);
    chk("wrap1", 64'(if1.wrap), 64'(m1_wrap));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the model reaches the given digit; bounded so the run cannot stall.
  task automatic run_until_an(input int target);
    int budget;
    budget = 40;
    while (m_an != target && budget > 0) begin
      cycle();
      budget--;
    end
    chk("reach_an", 64'(m_an == target), 64'h1);
  endtask

  initial begin
    if4.d    = 16'h0;
    if4.hold = 1'b0;
    if1.d    = 4'h0;
    if1.hold = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Basic scan of 0120
    if4.d = 16'h0120;
    run(20);

    // Value change mid-frame is deferred to the next wrap
    run_until_an(1);
    if4.d = 16'hA005;
    run(20);

    // Hold across several frames, then release
    if4.d = 16'h0120;
    run(16);
    if4.hold = 1'b1;
    if4.d    = 16'h0009;
    run(20);
    if4.hold = 1'b0;
    run(12);

    // All-zero value
    if4.d = 16'h0000;
    run(10);

    // Asynchronous reset mid-frame, between clock edges
    if4.d = 16'h0120;
    run(12);
`ifdef SEG_SCAN_LZB_EN
    run_until_an(2);
`else
    run_until_an(2);
`endif
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #3 rst = 1'b0;
    run(16);

    // Random traffic with varying leading zeros and hold
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        if4.d = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) if4.hold = ~if4.hold;
      if1.d    = 4'($urandom);
      if1.hold = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
